des_round_ctrl: RTL and testbench
=================================

// Module: des_round_ctrl
// PURPOSE
//  Sequencer for an iterative DES datapath: one Feistel round per clock, reused 16 times.
//  Accepts a job (direction flag e) over a valid/ready handshake.
//  Drives the load/round/final strobes, round index and per-round key-rotate command
//  (amount + direction).
//  Presents completion over a second valid/ready handshake. Sits between the host
//  interface and the L/R, C/D and IP/IP^-1 registers.
// PARAMETERS
//  ROUNDS  16  Feistel rounds per block; shift table below is defined for 16 only
//  CNT_W   5   round counter width; must hold ROUNDS
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      job request
//  in_ready   out  1      high only in IDLE
//  e          in   1      1 = encrypt, 0 = decrypt; sampled only on in_valid&&in_ready
//  ld_init    out  1      load IP(in) into L/R; load PC-1(k) into C/D
//  round_en   out  1      datapath executes one round this cycle
//  round_idx  out  CNT_W  current round, 1..ROUNDS; 0 outside ROUND
//  key_shift  out  2      C/D rotate amount this round (0,1,2)
//  key_dir    out  1      0 = rotate left (encrypt), 1 = rotate right (decrypt)
//  ld_final   out  1      capture IP^-1({R,L}) into output register
//  out_valid  out  1      result register holds a finished block
//  out_ready  in   1      consumer takes result
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (rst_n low at edge): state=IDLE, counter=0, dir_q=0.
//    All strobes, out_valid, round_idx, key_shift and key_dir = 0; in_ready=1 after that edge.
//    Reset mid-job abandons the job immediately; no ld_final, no out_valid.
//  - States: IDLE -> LOAD -> ROUND(xROUNDS) -> FINAL -> HOLD -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready latch dir_q=e and go to LOAD; otherwise stay.
//  - LOAD: 1 cycle, ld_init=1.
//  - ROUND: round_en=1, round_idx=n with n=1..16 on consecutive cycles.
//    Counter wraps to 0 on leaving ROUND.
//  - FINAL: 1 cycle, ld_final=1.
//  - HOLD: out_valid=1 until out_ready; on out_valid&&out_ready go to IDLE.
//  - No new accept in the HOLD->IDLE cycle.
//  - Latency: accept at edge T -> LOAD T+1, rounds T+2..T+17, FINAL T+18, out_valid from T+19.
//    Minimum spacing between accepts is 20 cycles.
//  - Key schedule, encrypt (dir_q=1): key_dir=0, key_shift by round 1..16 =
//    1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Cumulative rotation 28.
//  - Key schedule, decrypt (dir_q=0): key_dir=1, key_shift =
//    0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
//    Rotation applies before the subkey of that round.
//  - key_shift/key_dir are combinational from state, counter and dir_q; 0 outside ROUND.
//  - e and in_valid are ignored outside IDLE. out_ready is ignored outside HOLD.
//  - All strobes are mutually exclusive; at most one of ld_init/round_en/ld_final is high.
// CONFIGURATION
//  DES_CTRL_ABORT_EN defined:
//   - adds input port abort (1 bit).
//   - abort high at an edge in LOAD, ROUND or FINAL -> next state IDLE, counter=0.
//     No ld_final and no out_valid for that job.
//   - abort in HOLD or IDLE has no effect. rst_n has priority over abort.
//  DES_CTRL_ABORT_EN undefined: no abort port; a job always runs to HOLD.
// TESTING
//  1. Reset, then in_valid=1 with e=1 for 1 cycle -> ld_init at T+1; round_en T+2..T+17;
//     round_idx 1..16; ld_final T+18; out_valid T+19.
//  2. Encrypt job -> key_shift sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with key_dir=0;
//     sum 28. Decrypt job -> 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with key_dir=1.
//  3. out_ready=0 for 10 cycles after out_valid -> out_valid holds, in_ready=0, no strobes.
//     out_ready=1 -> IDLE next edge, in_ready=1.
//  4. e toggled and in_valid pulsed during ROUND -> ignored; direction and key schedule
//     follow the value latched at accept.
//  5. rst_n=0 at round 7 -> next cycle IDLE, all outputs 0, in_ready=1; no out_valid ever.
//  6. DES_CTRL_ABORT_EN: abort=1 at round 10 -> IDLE next cycle, no ld_final.
//     A new job accepted immediately after behaves as in test 1.

Source files
------------

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequencer for an iterative DES datapath.
// One Feistel round per clock, reused ROUNDS times per block.
// It accepts a job over in_valid/in_ready and presents completion over out_valid/out_ready.
// Optional build macro DES_CTRL_ABORT_EN adds an 'abort' input.
// Abort cancels a job that is in LOAD, ROUND or FINAL.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a job, in_ready high
// S_LOAD  | ld_init: IP(in) -> L/R, PC-1(k) -> C/D
// S_ROUND | one Feistel round per cycle, round_idx 1..ROUNDS
// S_FINAL | ld_final: IP^-1({R,L}) -> output register
// S_HOLD  | out_valid high until the consumer takes the result

module des_round_ctrl #(
    parameter int ROUNDS = 16,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             e,
`ifdef DES_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             ld_init,
    output logic             round_en,
    output logic [CNT_W-1:0] round_idx,
    output logic [1:0]       key_shift,
    output logic             key_dir,
    output logic             ld_final,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             abort_hit;

`ifdef DES_CTRL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // State, round counter and latched direction; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state logic and strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        in_ready  = 1'b0;
        ld_init   = 1'b0;
        round_en  = 1'b0;
        round_idx = '0;
        ld_final  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dir_d   = e;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_init = 1'b1;
                cnt_d   = CNT_W'(1);
                state_d = S_ROUND;
            end
            S_ROUND: begin
                round_en  = 1'b1;
                round_idx = cnt_q;
                if (cnt_q == CNT_W'(ROUNDS)) begin
                    cnt_d   = '0;
                    state_d = S_FINAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINAL: begin
                ld_final = 1'b1;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Abort only cancels work in flight; a finished block in HOLD is kept.
        if (abort_hit && (state_q == S_LOAD || state_q == S_ROUND || state_q == S_FINAL)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    assign busy = (state_q != S_IDLE);

    // Per-round C/D rotate command.
    // Decrypt skips the round-1 rotate because C/D already sit at the final
    // encrypt position (cumulative rotation 28).
    always_comb begin
        key_shift = 2'd0;
        key_dir   = 1'b0;
        if (state_q == S_ROUND) begin
            key_dir = ~dir_q;
            case (cnt_q)
                CNT_W'(1):  key_shift = dir_q ? 2'd1 : 2'd0;
                CNT_W'(2),
                CNT_W'(9),
                CNT_W'(16): key_shift = 2'd1;
                default:    key_shift = 2'd2;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl: per-round vector table plus hand sequences.
module tb_des_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       e = 1'b0;
    logic       out_ready = 1'b0;
    logic       abort = 1'b0;
    logic       in_ready, ld_init, round_en, key_dir, ld_final, out_valid, busy;
    logic [4:0] round_idx;
    logic [1:0] key_shift;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        int sh_enc;
        int sh_dec;
    } rvec_t;
    rvec_t tbl[16];

    des_round_ctrl #(.ROUNDS(16), .CNT_W(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .e(e),
`ifdef DES_CTRL_ABORT_EN
        .abort(abort),
`endif
        .ld_init(ld_init),
        .round_en(round_en),
        .round_idx(round_idx),
        .key_shift(key_shift),
        .key_dir(key_dir),
        .ld_final(ld_final),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " in_ready"},  int'(in_ready),  1);
        chk({tag, " busy"},      int'(busy),      0);
        chk({tag, " ld_init"},   int'(ld_init),   0);
        chk({tag, " round_en"},  int'(round_en),  0);
        chk({tag, " round_idx"}, int'(round_idx), 0);
        chk({tag, " key_shift"}, int'(key_shift), 0);
        chk({tag, " key_dir"},   int'(key_dir),   0);
        chk({tag, " ld_final"},  int'(ld_final),  0);
        chk({tag, " out_valid"}, int'(out_valid), 0);
    endtask

    // Full job from accept to return to IDLE.
    // hold_wait = cycles out_ready stays low in HOLD.
    // disturb   = toggle e and pulse in_valid/out_ready during ROUND.
    task automatic run_job(input logic e_val, input int hold_wait, input bit disturb);
        int sum;
        sum = 0;
        chk("pre in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        e        = e_val;
        step();
        in_valid = 1'b0;
        e        = ~e_val;
        chk("load ld_init", int'(ld_init), 1);
        chk("load round_en", int'(round_en), 0);
        chk("load in_ready", int'(in_ready), 0);
        chk("load busy", int'(busy), 1);
        chk("load key_shift", int'(key_shift), 0);
        for (int i = 0; i < 16; i++) begin
            if (disturb) begin
                in_valid  = 1'b1;
                e         = i[0];
                out_ready = ~i[0];
            end
            step();
            chk("round round_en", int'(round_en), 1);
            chk("round ld_init", int'(ld_init), 0);
            chk("round ld_final", int'(ld_final), 0);
            chk("round out_valid", int'(out_valid), 0);
            chk("round round_idx", int'(round_idx), tbl[i].idx);
            chk("round key_shift", int'(key_shift), e_val ? tbl[i].sh_enc : tbl[i].sh_dec);
            chk("round key_dir", int'(key_dir), e_val ? 0 : 1);
            sum += int'(key_shift);
        end
        chk("shift sum", sum, e_val ? 28 : 27);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        chk("final ld_final", int'(ld_final), 1);
        chk("final round_en", int'(round_en), 0);
        chk("final round_idx", int'(round_idx), 0);
        chk("final key_shift", int'(key_shift), 0);
        chk("final out_valid", int'(out_valid), 0);
        out_ready = (hold_wait == 0);
        step();
        chk("hold out_valid", int'(out_valid), 1);
        chk("hold in_ready", int'(in_ready), 0);
        for (int i = 0; i < hold_wait; i++) begin
            step();
            chk("wait out_valid", int'(out_valid), 1);
            chk("wait in_ready", int'(in_ready), 0);
            chk("wait strobes", int'(ld_init) + int'(round_en) + int'(ld_final), 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_idle_outputs("release");
    endtask

    initial begin
        tbl[0]  = '{1, 1, 0};  tbl[1]  = '{2, 1, 1};
        tbl[2]  = '{3, 2, 2};  tbl[3]  = '{4, 2, 2};
        tbl[4]  = '{5, 2, 2};  tbl[5]  = '{6, 2, 2};
        tbl[6]  = '{7, 2, 2};  tbl[7]  = '{8, 2, 2};
        tbl[8]  = '{9, 1, 1};  tbl[9]  = '{10, 2, 2};
        tbl[10] = '{11, 2, 2}; tbl[11] = '{12, 2, 2};
        tbl[12] = '{13, 2, 2}; tbl[13] = '{14, 2, 2};
        tbl[14] = '{15, 2, 2}; tbl[15] = '{16, 1, 1};

        // Reset.
        step();
        step();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        step();
        chk("idle stays", int'(busy), 0);

        // Basic encrypt, then decrypt.
        run_job(1'b1, 0, 1'b0);
        run_job(1'b0, 0, 1'b0);
        // Consumer stall of 10 cycles.
        run_job(1'b1, 10, 1'b0);
        // Input noise during ROUND is ignored.
        run_job(1'b0, 2, 1'b1);
        run_job(1'b1, 0, 1'b1);

        // Reset at round 7.
        in_valid = 1'b1;
        e        = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("pre-reset round_idx", int'(round_idx), 7);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle_outputs("midreset");
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 25; i++) begin
                step();
                seen += int'(out_valid) + int'(ld_final) + int'(busy);
            end
            chk("after reset no activity", seen, 0);
        end
        run_job(1'b0, 0, 1'b0);

`ifdef DES_CTRL_ABORT_EN
        // Abort at round 10.
        in_valid = 1'b1;
        e        = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("pre-abort round_idx", int'(round_idx), 10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle_outputs("abort");
        run_job(1'b1, 0, 1'b0);
        // Abort in HOLD has no effect.
        in_valid = 1'b1;
        e        = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 18; i++) step();
        chk("hold before abort", int'(out_valid), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("hold after abort", int'(out_valid), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_idle_outputs("hold-abort release");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
